// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU control path: widths, instruction
// field positions, opcode and sequencer state encodings.
package cpu_pkg;

   localparam int ADDR_WIDTH  = 10;
   localparam int DATA_WIDTH  = 9;
   localparam int INSTR_WIDTH = 22;

   // Instruction word layout
   localparam int OPC_MSB  = 21;
   localparam int OPC_LSB  = 18;
   localparam int SRCA_MSB = 17;
   localparam int SRCA_LSB = 15;
   localparam int SRCB_MSB = 14;
   localparam int SRCB_LSB = 12;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 9;
   localparam int IMM_MSB  = 8;
   localparam int IMM_LSB  = 0;

   // Source field value selecting imm9; as a destination it means "no write"
   localparam logic [2:0] REG_IMM = 3'd7;
   localparam int         NUM_REGS = 7;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_MOV  = 4'd5,
      OP_JMP  = 4'd13,
      OP_BZ   = 4'd14,
      OP_HALT = 4'd15
   } opcode_t;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_HALTED
   } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder for cpu_sequencer.
// Branch opcodes (JMP/BZ) are recognised only when CPU_SEQUENCER_BRANCH_EN
// is defined; otherwise they decode as ordinary ALU operations.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic [3:0]             opcode,
   output logic [2:0]             src_a,
   output logic [2:0]             src_b,
   output logic [2:0]             rd,
   output logic [DATA_WIDTH-1:0]  imm,
   output logic                   imm_a,
   output logic                   imm_b,
   output logic                   write_en,
   output logic                   is_halt,
   output logic                   is_jmp,
   output logic                   is_bz
);

   assign opcode = instr[OPC_MSB:OPC_LSB];
   assign src_a  = instr[SRCA_MSB:SRCA_LSB];
   assign src_b  = instr[SRCB_MSB:SRCB_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign imm    = instr[IMM_MSB:IMM_LSB];

   assign imm_a   = (src_a == REG_IMM);
   assign imm_b   = (src_b == REG_IMM);
   assign is_halt = (opcode == OP_HALT);

`ifdef CPU_SEQUENCER_BRANCH_EN
   assign is_jmp = (opcode == OP_JMP);
   assign is_bz  = (opcode == OP_BZ);
`else
   assign is_jmp = 1'b0;
   assign is_bz  = 1'b0;
`endif

   // Branches and HALT never write the register file; rd = 7 is a discard
   assign write_en = (rd != REG_IMM) && !is_halt && !is_jmp && !is_bz;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/WB sequencer for the 9-bit CPU. Owns the PC and
// the halt condition. Optional branch support (JMP/BZ, resolved in WB) is
// enabled by defining CPU_SEQUENCER_BRANCH_EN.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_WIDTH,
   parameter int DATA_W  = DATA_WIDTH,
   parameter int INSTR_W = INSTR_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   output logic [ADDR_W-1:0]  address,
   input  logic [INSTR_W-1:0] instr,
   output logic [2:0]         rd_addr_a,
   output logic [2:0]         rd_addr_b,
   input  logic [DATA_W-1:0]  rd_data_a,
   input  logic [DATA_W-1:0]  rd_data_b,
   output logic [3:0]         alu_opcode,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_out,
   output logic               reg_we,
   output logic [2:0]         reg_waddr,
   output logic [DATA_W-1:0]  reg_wdata,
   output logic               halted
);

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   wb_data;
   logic                br_take;
   logic [ADDR_W-1:0]   br_target;

   logic [3:0]          opcode;
   logic [2:0]          src_a;
   logic [2:0]          src_b;
   logic [2:0]          rd;
   logic [DATA_W-1:0]   imm;
   logic                imm_a;
   logic                imm_b;
   logic                write_en;
   logic                is_halt;
   logic                is_jmp;
   logic                is_bz;
   logic                take_now;
   logic [ADDR_W-1:0]   target_now;

   cpu_decode u_decode (
      .instr    (instr),
      .opcode   (opcode),
      .src_a    (src_a),
      .src_b    (src_b),
      .rd       (rd),
      .imm      (imm),
      .imm_a    (imm_a),
      .imm_b    (imm_b),
      .write_en (write_en),
      .is_halt  (is_halt),
      .is_jmp   (is_jmp),
      .is_bz    (is_bz)
   );

   assign address   = pc;
   assign reg_wdata = wb_data;

   // Branch target is imm9 zero-extended to the PC width; BZ tests operand A
   assign target_now = {{(ADDR_W-DATA_W){1'b0}}, imm};
   assign take_now   = is_jmp || (is_bz && (alu_a == '0));

   // Read ports and ALU operands are live only in EXEC so the whole
   // RAM -> regfile -> ALU path settles within that one cycle
   always_comb begin
      rd_addr_a  = '0;
      rd_addr_b  = '0;
      alu_opcode = '0;
      alu_a      = '0;
      alu_b      = '0;
      if (state == ST_EXEC) begin
         rd_addr_a  = src_a;
         rd_addr_b  = src_b;
         alu_opcode = opcode;
         alu_a      = imm_a ? imm : rd_data_a;
         alu_b      = imm_b ? imm : rd_data_b;
      end
   end

   // Sequencer FSM: PC, writeback capture, write strobe and halt flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_FETCH;
         pc        <= '0;
         wb_data   <= '0;
         reg_we    <= 1'b0;
         reg_waddr <= '0;
         br_take   <= 1'b0;
         br_target <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (run) state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (is_halt) begin
                  halted <= 1'b1;
                  state  <= ST_HALTED;
               end else begin
                  wb_data   <= alu_out;
                  reg_waddr <= rd;
                  reg_we    <= write_en;
                  br_take   <= take_now;
                  br_target <= target_now;
                  state     <= ST_WB;
               end
            end
            ST_WB: begin
               reg_we <= 1'b0;
               pc     <= br_take ? br_target : pc + ADDR_W'(1);
               state  <= ST_FETCH;
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction RAM, register file
// and ALU are modelled here, and an instruction-level reference model
// predicts every address, operand and register write.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   localparam int AW = 10;
   localparam int DW = 9;
   localparam int IW = 22;

   logic          clock = 1'b0;
   logic          reset;
   logic          run;
   logic [AW-1:0] address;
   logic [IW-1:0] instr;
   logic [2:0]    rd_addr_a;
   logic [2:0]    rd_addr_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic [3:0]    alu_opcode;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_out;
   logic          reg_we;
   logic [2:0]    reg_waddr;
   logic [DW-1:0] reg_wdata;
   logic          halted;

   int checks   = 0;
   int failures = 0;

   logic [IW-1:0] ram     [0:1023];
   logic [DW-1:0] rf      [0:6];
   logic [DW-1:0] rf_seed [0:6];
   logic          rf_load = 1'b0;

   logic [DW-1:0] m_regs  [0:6];
   logic [AW-1:0] m_pc;

   always #5 clock = ~clock;

   cpu_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .address    (address),
      .instr      (instr),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_out    (alu_out),
      .reg_we     (reg_we),
      .reg_waddr  (reg_waddr),
      .reg_wdata  (reg_wdata),
      .halted     (halted)
   );

   function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a;
         4'd6:    return b;
         default: return a + b + DW'(op);
      endcase
   endfunction

   function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [2:0] sa,
                                        input logic [2:0] sb, input logic [2:0] d,
                                        input logic [8:0] imm);
      return {op, sa, sb, d, imm};
   endfunction

   // Synchronous instruction RAM
   always @(posedge clock) instr <= ram[address];

   // Register file: 7 entries, combinational read, write on the edge ending WB
   always @(posedge clock) begin
      if (rf_load) rf <= rf_seed;
      else if (reg_we && reg_waddr != 3'd7) rf[reg_waddr] <= reg_wdata;
   end
   assign rd_data_a = (rd_addr_a != 3'd7) ? rf[rd_addr_a] : '0;
   assign rd_data_b = (rd_addr_b != 3'd7) ? rf[rd_addr_b] : '0;
   assign alu_out   = alu_fn(alu_opcode, alu_a, alu_b);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 1024; i++) ram[i] = mk(4'd0, 3'd7, 3'd7, 3'd7, 9'd0);
   endtask

   // Reset with fresh random register contents; model starts from the same state
   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      for (int i = 0; i < 7; i++) begin
         rf_seed[i] = DW'($urandom);
         m_regs[i]  = rf_seed[i];
      end
      rf_load = 1'b1;
      tick();
      rf_load = 1'b0;
      check("rst_address", address, 0);
      check("rst_reg_we", reg_we, 0);
      check("rst_reg_waddr", reg_waddr, 0);
      check("rst_reg_wdata", reg_wdata, 0);
      check("rst_alu_opcode", alu_opcode, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_rd_addr_a", rd_addr_a, 0);
      check("rst_rd_addr_b", rd_addr_b, 0);
      check("rst_halted", halted, 0);
      m_pc  = '0;
      reset = 1'b0;
   endtask

   // Execute one instruction in the model and check the DUT cycle by cycle.
   // Entered at FETCH with run = 1; returns at the next FETCH (or in HALTED).
   task automatic step_instr(input bit wiggle);
      logic [IW-1:0] w;
      logic [3:0]    op;
      logic [2:0]    sa, sb, d;
      logic [8:0]    imm;
      logic [DW-1:0] a, b, res;
      logic [AW-1:0] npc;
      logic          we;
      w   = ram[m_pc];
      op  = w[21:18];
      sa  = w[17:15];
      sb  = w[14:12];
      d   = w[11:9];
      imm = w[8:0];
      a   = (sa == 3'd7) ? imm : m_regs[sa];
      b   = (sb == 3'd7) ? imm : m_regs[sb];
      check("fetch_addr", address, m_pc);
      check("fetch_we", reg_we, 0);
      check("fetch_halted", halted, 0);
      tick();
      if (wiggle) run = 1'($urandom_range(0, 1));
      check("exec_addr", address, m_pc);
      check("exec_opcode", alu_opcode, op);
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      if (op == 4'd15) begin
         tick();
         check("halt_flag", halted, 1);
         check("halt_addr", address, m_pc);
         check("halt_we", reg_we, 0);
      end else begin
         res = alu_fn(op, a, b);
         npc = m_pc + AW'(1);
         we  = (d != 3'd7);
`ifdef CPU_SEQUENCER_BRANCH_EN
         if (op == 4'd13) begin
            npc = {1'b0, imm};
            we  = 1'b0;
         end
         if (op == 4'd14) begin
            if (a == '0) npc = {1'b0, imm};
            we = 1'b0;
         end
`endif
         tick();
         run = 1'b1;
         check("wb_we", reg_we, we);
         if (we) begin
            check("wb_waddr", reg_waddr, d);
            check("wb_wdata", reg_wdata, res);
            m_regs[d] = res;
         end
         tick();
         m_pc = npc;
      end
   endtask

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      fill_nop();

      // Three ALU ops writing r0, r1, r2: exact per-cycle address and strobe
      ram[0] = mk(4'd0, 3'd7, 3'd7, 3'd0, 9'd3);
      ram[1] = mk(4'd1, 3'd0, 3'd7, 3'd1, 9'd1);
      ram[2] = mk(4'd4, 3'd0, 3'd1, 3'd2, 9'd0);
      do_reset();
      run = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         check("seq_addr", address, (c - 1) / 3);
         check("seq_we", reg_we, (c % 3 == 0) ? 1 : 0);
         if (c % 3 == 0) check("seq_waddr", reg_waddr, c / 3 - 1);
         tick();
      end
      check("seq_addr_end", address, 3);

      // MOVI into r3, discard write, dependent read, then HALT at 5
      fill_nop();
      ram[0] = mk(4'd5, 3'd7, 3'd7, 3'd3, 9'h1A5);
      ram[1] = mk(4'd0, 3'd1, 3'd2, 3'd7, 9'd0);
      ram[2] = mk(4'd0, 3'd3, 3'd3, 3'd4, 9'd0);
      ram[3] = mk(4'd4, 3'd4, 3'd7, 3'd5, 9'h0F0);
      ram[4] = mk(4'd2, 3'd5, 3'd3, 3'd6, 9'd0);
      ram[5] = mk(4'd15, 3'd0, 3'd0, 3'd0, 9'd0);
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 6; i++) step_instr(1'b0);
      check("movi_r3", rf[3], 9'h1A5);
      check("dep_r4", rf[4], 9'h14A);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("halted_hold", halted, 1);
         check("halted_addr", address, 5);
         check("halted_we", reg_we, 0);
      end

      // Stall: run = 0 in FETCH holds the address with no write
      fill_nop();
      ram[0] = mk(4'd0, 3'd1, 3'd7, 3'd2, 9'd7);
      ram[1] = mk(4'd3, 3'd2, 3'd7, 3'd1, 9'h055);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check("stall_addr", address, 0);
         check("stall_we", reg_we, 0);
         tick();
      end
      run = 1'b1;
      step_instr(1'b0);

      // Reset asserted during WB aborts the write and returns pc to 0
      tick();
      tick();
      check("wb_before_rst", reg_we, 1);
      check("wb_addr_before_rst", address, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_we", reg_we, 0);
      check("rst_mid_addr", address, 0);
      tick();
      check("rst_mid_addr_held", address, 0);

      // PC wraps from 1023 to 0
      fill_nop();
      do_reset();
      run = 1'b1;
      repeat (3 * 1023) tick();
      m_pc = AW'(1023);
      step_instr(1'b0);
      check("wrap_addr", address, 0);

`ifdef CPU_SEQUENCER_BRANCH_EN
      // BZ with operand A = 0 goes to imm9, then JMP back
      fill_nop();
      ram[0]  = mk(4'd5, 3'd7, 3'd7, 3'd0, 9'd0);
      ram[1]  = mk(4'd14, 3'd0, 3'd7, 3'd2, 9'd40);
      ram[40] = mk(4'd13, 3'd7, 3'd7, 3'd1, 9'd7);
      do_reset();
      run = 1'b1;
      step_instr(1'b0);
      step_instr(1'b0);
      check("bz_taken_addr", address, 40);
      step_instr(1'b0);
      check("jmp_addr", address, 7);
`endif

      // Random programs against the instruction-level model
      for (int i = 0; i < 1024; i++) begin
         ram[i] = IW'($urandom);
         if (ram[i][21:18] == 4'd15) ram[i][21:18] = 4'd0;
      end
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 120; i++) step_instr(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
